sha3_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `sha3` core between NREQ independent requesters. It grants one requester at a time and drives that requester's mode, permutation count and message block onto the core. It pulses the core's start, tracks the core's done level through its clear-then-set sequence, and returns the captured digest. It sits directly above the `sha3` core and replaces per-client direct wiring to the core.

---
 rtl/sha3_arbiter_if.sv | 25 ++
 rtl/sha3_arbiter.sv | 135 +++++++++++++
 tb/tb_sha3_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_arbiter_if.sv
// Requester-side bus of the shared SHA-3 arbiter: per-requester request slices,
// one-hot grant, response pulses and the shared digest.
interface sha3_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_mode;
  logic [8*NREQ-1:0]    req_nperm;
  logic [1152*NREQ-1:0] req_data;
  logic [NREQ-1:0]      req_grant;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_err;
  logic [511:0]         rsp_digest;
  logic                 busy;

  modport master (
    output req_valid, req_mode, req_nperm, req_data,
    input  req_grant, rsp_valid, rsp_err, rsp_digest, busy
  );

  modport slave (
    input  req_valid, req_mode, req_nperm, req_data,
    output req_grant, rsp_valid, rsp_err, rsp_digest, busy
  );
endinterface

// File: rtl/sha3_arbiter.sv
// Round-robin arbiter/sequencer sharing one sha3 core between NREQ requesters,
// with stale-done filtering and a start-to-done watchdog.
module sha3_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           reset,
  sha3_arbiter_if.slave  req,
  output logic           core_start,
  output logic [9:0]     core_ctrl,
  output logic [1151:0]  core_in,
  input  logic           core_done,
  input  logic [511:0]   core_out
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, START, CLEAR, RUN, RESP, DRAIN} state_t;

  state_t        state;
  logic [GW-1:0] grant_idx;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] winner;
  logic [GW-1:0] cand;
  logic          found;
  logic [CW-1:0] wdog;
  logic          err;
  logic          wd_expire;

  // First requesting index after the last served one, wrapping around.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = GW'((32'(last_grant) + i) % NREQ);
      if (!found && req.req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign wd_expire = (wdog == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      grant_idx      <= '0;
      last_grant     <= GW'(NREQ - 1);
      wdog           <= '0;
      err            <= 1'b0;
      req.req_grant  <= '0;
      req.rsp_valid  <= '0;
      req.rsp_err    <= '0;
      req.rsp_digest <= '0;
      req.busy       <= 1'b0;
      core_start     <= 1'b0;
      core_ctrl      <= '0;
      core_in        <= '0;
    end else begin
      core_start    <= 1'b0;
      req.rsp_valid <= '0;
      req.rsp_err   <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_idx     <= winner;
            req.req_grant <= NREQ'(1) << winner;
            core_start    <= 1'b1;
            core_ctrl     <= {req.req_nperm[8*32'(winner) +: 8],
                              req.req_mode[2*32'(winner) +: 2]};
            core_in       <= req.req_data[1152*32'(winner) +: 1152];
            req.busy      <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          wdog  <= '0;
          state <= CLEAR;
        end
        // Wait for the previous operation's done level to clear.
        CLEAR: begin
          wdog <= wdog + CW'(1);
          if (!core_done) begin
            state <= RUN;
          end else if (wd_expire) begin
            err           <= 1'b1;
            req.rsp_valid <= req.req_grant;
            req.rsp_err   <= req.req_grant;
            state         <= RESP;
          end
        end
        RUN: begin
          wdog <= wdog + CW'(1);
          if (core_done) begin
            err            <= 1'b0;
            req.rsp_digest <= core_out;
            req.rsp_valid  <= req.req_grant;
            state          <= RESP;
          end else if (wd_expire) begin
            err           <= 1'b1;
            req.rsp_valid <= req.req_grant;
            req.rsp_err   <= req.req_grant;
            state         <= RESP;
          end
        end
        RESP: begin
          last_grant    <= grant_idx;
          req.req_grant <= '0;
          core_ctrl     <= '0;
          core_in       <= '0;
          if (err) begin
            state <= DRAIN;
          end else begin
            req.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        // Timed-out core must finish before it can be reused.
        DRAIN: begin
          if (core_done) begin
            req.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_arbiter.sv
// Scoreboard bench for sha3_arbiter: directed requests against a simple core
// model with configurable done-drop and done-rise delays.
module tb_sha3_arbiter;
  localparam int unsigned NREQ = 2;
  localparam int unsigned TOUT = 16;
  localparam logic [255:0] ABC_VEC =
    256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha3_arbiter_if #(.NREQ(NREQ)) bus ();

  logic          core_start;
  logic [9:0]    core_ctrl;
  logic [1151:0] core_in;
  logic          core_done;
  logic [511:0]  core_out;

  sha3_arbiter #(.NREQ(NREQ), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .req(bus),
    .core_start(core_start), .core_ctrl(core_ctrl), .core_in(core_in),
    .core_done(core_done), .core_out(core_out)
  );

  logic [1151:0] abc_blk;

  function automatic logic [511:0] core_fn(logic [1151:0] d, logic [9:0] c);
    if (d == abc_blk) return {256'd0, ABC_VEC};
    return d[511:0] ^ {502'd0, c};
  endfunction

  // Core model: done falls drop_d cycles and rises lat cycles after start.
  int           lat = 5;
  int           drop_d = 1;
  bit           stuck = 1'b0;
  bit           stuck_val = 1'b0;
  logic         done_r;
  logic [511:0] saved;
  int           mcnt;
  bit           running;

  assign core_done = stuck ? stuck_val : done_r;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      done_r   <= 1'b0;
      core_out <= '0;
      saved    <= '0;
      running  <= 1'b0;
      mcnt     <= 0;
    end else if (core_start) begin
      running <= 1'b1;
      mcnt    <= 1;
      saved   <= core_fn(core_in, core_ctrl);
    end else if (running) begin
      mcnt <= mcnt + 1;
      if (mcnt == drop_d) done_r <= 1'b0;
      if (mcnt == lat && !stuck) begin
        done_r   <= 1'b1;
        core_out <= saved;
        running  <= 1'b0;
      end
    end
  end

  typedef struct {
    int           idx;
    bit           err;
    logic [511:0] dig;
    logic [9:0]   ctrl;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_rsp = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(int idx, bit err, logic [511:0] dig, logic [9:0] ctrl, int l);
    exp_t e;
    e.idx = idx; e.err = err; e.dig = dig; e.ctrl = ctrl; e.lat = l;
    return e;
  endfunction

  // Monitor: checks grant/ctrl at each start and pops one entry per response.
  exp_t            em;
  logic [NREQ-1:0] oh;
  always @(negedge clk) begin
    if (!reset) begin
      cyc++;
      if (core_start) begin
        start_cyc = cyc;
        if (sb.size() > 0) begin
          oh = NREQ'(1) << sb[0].idx;
          chk("start_grant", 512'(bus.req_grant), 512'(oh));
          chk("start_ctrl", 512'(core_ctrl), 512'(sb[0].ctrl));
        end else begin
          chk("start_without_expect", 512'(sb.size()), 512'(1));
        end
      end
      if (|bus.rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_without_expect", 512'(bus.rsp_valid), 512'(0));
        end else begin
          em = sb.pop_front();
          oh = NREQ'(1) << em.idx;
          chk("rsp_valid", 512'(bus.rsp_valid), 512'(oh));
          chk("rsp_err", 512'(bus.rsp_err), em.err ? 512'(oh) : 512'(0));
          chk("rsp_digest", bus.rsp_digest, em.dig);
          chk("rsp_grant", 512'(bus.req_grant), 512'(oh));
          chk("rsp_latency", 512'(cyc - start_cyc), 512'(em.lat));
        end
        n_rsp++;
      end
    end
  end

  task automatic set_req(int i, logic [1:0] m, logic [7:0] np, logic [1151:0] d);
    bus.req_mode[2*i +: 2]     = m;
    bus.req_nperm[8*i +: 8]    = np;
    bus.req_data[1152*i +: 1152] = d;
  endtask

  task automatic wait_rsp(int target, int budget);
    int n = 0;
    while (n_rsp < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    n_chk++;
    if (n_rsp >= target) n_pass++;
    else $display("FAIL wait_rsp: responses %0d expected %0d", n_rsp, target);
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_grant"}, 512'(bus.req_grant), 512'(0));
    chk({tag, "_rsp_valid"}, 512'(bus.rsp_valid), 512'(0));
    chk({tag, "_rsp_err"}, 512'(bus.rsp_err), 512'(0));
    chk({tag, "_digest"}, bus.rsp_digest, 512'(0));
    chk({tag, "_busy"}, 512'(bus.busy), 512'(0));
    chk({tag, "_core_start"}, 512'(core_start), 512'(0));
    chk({tag, "_core_ctrl"}, 512'(core_ctrl), 512'(0));
    chk({tag, "_core_in"}, 512'(core_in), 512'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  logic [1151:0] d1, d2, da, db, dc, dd;
  logic [511:0]  last_dig;
  int            base;

  initial begin
    abc_blk = '0;
    abc_blk[31:0]      = 32'h0663_6261;
    abc_blk[1087:1080] = 8'h80;
    d1 = {36{32'h1111_0003}};
    d2 = {36{32'h2222_0004}};
    da = {36{32'hA5A5_0001}};
    db = {36{32'h5A5A_0002}};
    dc = {36{32'hC0C0_0005}};
    dd = {36{32'hD0D0_0006}};
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_mode  = '0;
    bus.req_nperm = '0;
    bus.req_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk) reset = 1'b0;

    // Single request: SHA3-256("abc") block on requester 0.
    @(negedge clk);
    set_req(0, 2'b11, 8'd0, abc_blk);
    sb.push_back(mk(0, 1'b0, {256'd0, ABC_VEC}, 10'h003, lat + 2));
    bus.req_valid = 2'b01;
    @(posedge clk); #1;
    chk("single_core_start", 512'(core_start), 512'(1));
    chk("single_grant", 512'(bus.req_grant), 512'(2'b01));
    chk("single_busy", 512'(bus.busy), 512'(1));
    bus.req_valid = 2'b00;
    wait_rsp(n_rsp + 1, 40);
    chk("single_idle_busy", 512'(bus.busy), 512'(0));
    chk("single_idle_grant", 512'(bus.req_grant), 512'(0));

    // Back-to-back with done held high from the previous operation.
    drop_d = 3;
    lat    = 6;
    @(negedge clk);
    set_req(0, 2'b00, 8'h05, d1);
    sb.push_back(mk(0, 1'b0, core_fn(d1, 10'h014), 10'h014, 8));
    sb.push_back(mk(0, 1'b0, core_fn(d2, 10'h022), 10'h022, 8));
    bus.req_valid = 2'b01;
    base = n_rsp;
    wait_rsp(base + 1, 40);
    set_req(0, 2'b10, 8'h08, d2);
    wait_rsp(base + 2, 40);
    bus.req_valid = 2'b00;
    drop_d = 1;
    lat    = 5;

    // Contention after reset: strict 0,1,0,1 alternation.
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    sb.delete();
    set_req(0, 2'b01, 8'h12, da);
    set_req(1, 2'b10, 8'h34, db);
    for (int k = 0; k < 2; k++) begin
      sb.push_back(mk(0, 1'b0, core_fn(da, 10'h049), 10'h049, 7));
      sb.push_back(mk(1, 1'b0, core_fn(db, 10'h0D2), 10'h0D2, 7));
    end
    bus.req_valid = 2'b11;
    wait_rsp(n_rsp + 4, 100);
    bus.req_valid = 2'b00;
    last_dig = core_fn(db, 10'h0D2);

    // Timeout: done never rises; digest must be preserved, then drain.
    stuck = 1'b1;
    stuck_val = 1'b0;
    @(negedge clk);
    set_req(0, 2'b00, 8'h01, dc);
    sb.push_back(mk(0, 1'b1, last_dig, 10'h004, TOUT + 1));
    bus.req_valid = 2'b01;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_rsp(n_rsp + 1, 60);
    chk("drain_busy", 512'(bus.busy), 512'(1));
    chk("drain_grant", 512'(bus.req_grant), 512'(0));
    chk("drain_core_ctrl", 512'(core_ctrl), 512'(0));
    chk("drain_core_in", 512'(core_in), 512'(0));
    chk("drain_digest", bus.rsp_digest, last_dig);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_hold_busy", 512'(bus.busy), 512'(1));
    stuck_val = 1'b1;
    @(posedge clk); #1;
    chk("drain_exit_busy", 512'(bus.busy), 512'(0));
    stuck = 1'b0;
    stuck_val = 1'b0;

    // Reset while RUN: everything clears, requester 0 wins next.
    lat = 12;
    @(negedge clk);
    set_req(0, 2'b11, 8'h02, dd);
    sb.push_back(mk(0, 1'b0, '0, 10'h00B, 14));
    bus.req_valid = 2'b01;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_idle_outputs("midrst");
    sb.delete();
    @(negedge clk) reset = 1'b0;
    lat = 5;
    sb.push_back(mk(0, 1'b0, core_fn(dd, 10'h00B), 10'h00B, 7));
    bus.req_valid = 2'b11;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_rsp(n_rsp + 1, 40);
    base = n_rsp;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_no_extra_rsp", 512'(n_rsp), 512'(base));
    chk("post_rst_busy", 512'(bus.busy), 512'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
